disp_filter: RTL and testbench
==============================

Name: disp_filter

Overview:
- Temporal filter between the disparity search (topcalc, 6-bit `move`) and the disparity-to-distance converter (calcdistance).
- Accepts one raw disparity per result strobe and rejects isolated outliers.
- Keeps a 2^LOG2_DEPTH-deep moving average and presents a stable, hysteresis-gated disparity so the 7-segment display stops flickering.

Parameters:
- DW, 6: disparity width in bits.
- LOG2_DEPTH, 3: log2 of the averaging window (window = 8 samples).
- OUTLIER_TH, 8: a sample with |d_in - q| > OUTLIER_TH is an outlier.
- REJECT_CNT, 3: this many consecutive outliers are treated as a scene change.
- HYST, 1: minimum |avg - q| that updates q. A value of 0 updates q on every accepted sample.

Ports:
- clk, input, 1: calculation clock (sysclk domain).
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- d_in, input, DW: raw disparity from the search stage.
- d_valid, input, 1: one-cycle strobe, d_in valid. Back-to-back strobes are allowed.
- clear, input, 1: synchronous flush request.
- q, output, DW: filtered disparity, to calcdistance.
- q_valid, output, 1: one-cycle pulse when q changes.
- locked, output, 1: window full and q meaningful.
- busy, output, 1: FLUSH in progress; d_valid is ignored while high.

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY; q=0, q_valid=0, locked=0, busy=0.
  - sum=0, ptr=0, out_cnt=0, pipeline valid=0.
  - Buffer contents need not be reset.
- Internal state:
  - buf: 2^LOG2_DEPTH x DW register array.
  - sum: DW+LOG2_DEPTH bits, always equal to the sum of buf outside FLUSH.
  - out_cnt: consecutive-outlier counter, saturating at REJECT_CNT.
- EMPTY:
  - On d_valid: fill_val<=d_in, ptr<=0, busy<=1, go to FLUSH.
- FLUSH:
  - Each cycle: buf[ptr]<=fill_val, ptr++.
  - On the write to index 2^LOG2_DEPTH-1: sum<=fill_val<<LOG2_DEPTH, ptr<=0, q<=fill_val, q_valid<=1, locked<=1, busy<=0, go to RUN.
  - q_valid is high exactly 2^LOG2_DEPTH+1 cycles after the cycle d_valid was sampled.
  - d_valid during FLUSH is dropped.
- RUN, on d_valid: compute diff=|d_in - q| using the current q register.
  - Case diff > OUTLIER_TH and out_cnt+1 < REJECT_CNT:
    - out_cnt++.
    - Sample dropped; no buffer or sum change.
  - Case diff > OUTLIER_TH and out_cnt+1 == REJECT_CNT (scene change):
    - out_cnt<=0, fill_val<=d_in, ptr<=0.
    - locked<=0, busy<=1, go to FLUSH.
    - q is held until FLUSH completes.
  - Case diff <= OUTLIER_TH:
    - out_cnt<=0.
    - sum<=sum - buf[ptr] + d_in; buf[ptr]<=d_in; ptr++ (wraps modulo depth).
    - Set stage-2 valid.
- Stage 2 (the cycle after acceptance):
  - avg=(sum + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH, rounded half-up. It never exceeds 2^DW-1, so no saturation is needed.
  - If |avg - q| >= HYST: q<=avg and q_valid<=1 on that edge.
  - Accepted-sample-to-q latency is 2 cycles.
- Back-to-back accepts: an outlier test in the same cycle as a stage-2 update uses the pre-update q.
- q_valid is never high for more than 1 cycle, except on consecutive stage-2 updates.
- clear (synchronous, priority over everything):
  - state<=EMPTY; locked=0, busy=0; sum=0, ptr=0, out_cnt=0.
  - Stage-2 valid is cancelled; q holds its value; no q_valid.
  - clear during FLUSH aborts the FLUSH.
- Async reset mid-FLUSH or mid-RUN produces the reset values immediately; the first post-reset d_valid starts a new FLUSH.

Decomposition:
- Shared include disp_pkg.vh holds:
  - the state encodings (EMPTY=2'd0, FLUSH=2'd1, RUN=2'd2);
  - the default DW=6 and LOG2_DEPTH=3, reused by calcdistance.
- One sub-module, disp_ring_buf:
  - Contents: register array, ptr, running sum.
  - Interface: write/flush-write ports, combinational old-entry read, sum output.
- disp_filter keeps the FSM, outlier logic, averaging stage and hysteresis.

Test Plan (defaults):
1. Reset, then d_valid with d_in=20 -> busy high for 8 cycles; q=20 and q_valid pulse 9 cycles after the strobe; locked=1; sum=160.
2. Window all 20, d_in=28 -> sum=168, avg=(172)>>3=21 -> q=21 with q_valid 2 cycles after the strobe.
3. Window all 20, d_in=21 -> sum=161, avg=20 -> no q_valid, q=20. Then d_in=28 -> sum=169, avg=21 -> q=21.
4. q=20, d_in=40 twice -> both dropped, q=20, locked=1. A third 40 -> locked=0, busy 8 cycles, q=40, q_valid, locked=1.
5. q=20, sequence 40, 40, 22, 40 -> 22 accepted (out_cnt reset), final 40 dropped, no FLUSH.
6. Assert clear on FLUSH cycle 4 -> state EMPTY, busy=0, no q_valid, q unchanged. Then assert rst_n=0 mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Purpose  : Shared disparity-path constants (FSM encodings, default widths).
// Revision : 1.0
// ============================================================================
package disp_pkg;

    localparam int DISP_DW         = 6;
    localparam int DISP_LOG2_DEPTH = 3;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/disp_ring_buf.sv
`default_nettype none
// ============================================================================
// Module   : disp_ring_buf
// Purpose  : Circular sample window with write pointer and running sum.
// Revision : 1.0
// ============================================================================
module disp_ring_buf
    import disp_pkg::*;
#(
    parameter int DW         = DISP_DW,
    parameter int LOG2_DEPTH = DISP_LOG2_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     restart,
    input  logic                     flush_wr,
    input  logic                     acc_wr,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            old_data,
    output logic [DW+LOG2_DEPTH-1:0] sum,
    output logic                     ptr_last
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DW + LOG2_DEPTH;

    logic [DW-1:0]         mem [DEPTH];
    logic [LOG2_DEPTH-1:0] ptr;

    assign old_data = mem[ptr];
    assign ptr_last = (ptr == LOG2_DEPTH'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!clear && (flush_wr || acc_wr)) begin
            mem[ptr] <= wr_data;
        end
    end

    // During a flush the sum is meaningless until the last write seeds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            sum <= '0;
        end else if (clear) begin
            ptr <= '0;
            sum <= '0;
        end else if (restart) begin
            ptr <= '0;
        end else if (flush_wr) begin
            if (ptr_last) begin
                sum <= SW'(wr_data) << LOG2_DEPTH;
            end
            ptr <= ptr + LOG2_DEPTH'(1);
        end else if (acc_wr) begin
            sum <= sum - SW'(old_data) + SW'(wr_data);
            ptr <= ptr + LOG2_DEPTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/disp_filter.sv
`default_nettype none
// ============================================================================
// Module   : disp_filter
// Purpose  : Outlier-rejecting moving-average filter with hysteresis output.
// Revision : 1.0
// ============================================================================
module disp_filter
    import disp_pkg::*;
#(
    parameter int DW         = DISP_DW,
    parameter int LOG2_DEPTH = DISP_LOG2_DEPTH,
    parameter int OUTLIER_TH = 8,
    parameter int REJECT_CNT = 3,
    parameter int HYST       = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d_in,
    input  logic          d_valid,
    input  logic          clear,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic          locked,
    output logic          busy
);

    localparam int SW = DW + LOG2_DEPTH;
    localparam int CW = $clog2(REJECT_CNT + 1);
    localparam logic [CW-1:0] REJ_LAST = CW'(REJECT_CNT - 1);
    localparam logic [SW-1:0] ROUND    = SW'(1) << (LOG2_DEPTH - 1);

    logic [1:0]    state;
    logic [DW-1:0] fill_val;
    logic [CW-1:0] out_cnt;
    logic          s2_valid;

    logic [DW-1:0] diff, avg, avg_diff, old_data, wr_data;
    logic [SW-1:0] sum;
    logic          ptr_last, is_outlier, run_strobe, accept, scene_chg;
    logic          empty_go, restart, flush_wr;

    assign diff       = (d_in >= q) ? (d_in - q) : (q - d_in);
    assign is_outlier = int'(diff) > OUTLIER_TH;
    assign run_strobe = d_valid && (state == ST_RUN) && !clear;
    assign accept     = run_strobe && !is_outlier;
    assign scene_chg  = run_strobe && is_outlier && (out_cnt == REJ_LAST);
    assign empty_go   = d_valid && (state == ST_EMPTY) && !clear;
    assign restart    = empty_go || scene_chg;
    assign flush_wr   = (state == ST_FLUSH) && !clear;
    assign wr_data    = flush_wr ? fill_val : d_in;

    // Sum already includes the accepted sample when stage 2 runs.
    assign avg      = DW'((sum + ROUND) >> LOG2_DEPTH);
    assign avg_diff = (avg >= q) ? (avg - q) : (q - avg);

    disp_ring_buf #(
        .DW         (DW),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .restart  (restart),
        .flush_wr (flush_wr),
        .acc_wr   (accept),
        .wr_data  (wr_data),
        .old_data (old_data),
        .sum      (sum),
        .ptr_last (ptr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            fill_val <= '0;
            out_cnt  <= '0;
            s2_valid <= 1'b0;
            q        <= '0;
            q_valid  <= 1'b0;
            locked   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (clear) begin
                state    <= ST_EMPTY;
                out_cnt  <= '0;
                s2_valid <= 1'b0;
                locked   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                s2_valid <= accept;
                if (s2_valid && (int'(avg_diff) >= HYST)) begin
                    q       <= avg;
                    q_valid <= 1'b1;
                end
                case (state)
                    ST_EMPTY: begin
                        if (d_valid) begin
                            fill_val <= d_in;
                            busy     <= 1'b1;
                            state    <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (ptr_last) begin
                            q       <= fill_val;
                            q_valid <= 1'b1;
                            locked  <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (d_valid) begin
                            if (!is_outlier) begin
                                out_cnt <= '0;
                            end else if (out_cnt == REJ_LAST) begin
                                out_cnt  <= '0;
                                fill_val <= d_in;
                                locked   <= 1'b0;
                                busy     <= 1'b1;
                                state    <= ST_FLUSH;
                            end else begin
                                out_cnt <= out_cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_filter
// Purpose  : Self-checking bench for disp_filter (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_disp_filter;

    typedef struct {
        logic [5:0] d;
        bit         upd;
        int         exp_q;
    } vec_t;

    typedef struct {
        int val;
        int cyc;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] d_in;
    logic       d_valid;
    logic       clear;
    logic [5:0] q;
    logic       q_valid;
    logic       locked;
    logic       busy;

    int  cyc    = 0;
    int  checks = 0;
    int  passed = 0;
    sb_t sb[$];
    vec_t vecs[10];

    disp_filter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .d_valid (d_valid),
        .clear   (clear),
        .q       (q),
        .q_valid (q_valid),
        .locked  (locked),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] d, input bit upd, input int eq, input int lat);
        if (upd) sb.push_back('{val: eq, cyc: cyc + lat});
        d_in    = d;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && q_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("qv_unexpected_sb_size", sb.size(), 1);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("qv_value", int'(q), e.val);
                chk("qv_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int bcnt;
        // window all 20, q=20: expected q after each strobe
        vecs[0] = '{d: 6'd28, upd: 1'b1, exp_q: 21};
        vecs[1] = '{d: 6'd21, upd: 1'b0, exp_q: 21};
        vecs[2] = '{d: 6'd40, upd: 1'b0, exp_q: 21};
        vecs[3] = '{d: 6'd40, upd: 1'b0, exp_q: 21};
        vecs[4] = '{d: 6'd22, upd: 1'b0, exp_q: 21};
        vecs[5] = '{d: 6'd40, upd: 1'b0, exp_q: 21};
        vecs[6] = '{d: 6'd29, upd: 1'b1, exp_q: 23};
        vecs[7] = '{d: 6'd13, upd: 1'b0, exp_q: 23};
        vecs[8] = '{d: 6'd15, upd: 1'b1, exp_q: 22};
        vecs[9] = '{d: 6'd22, upd: 1'b0, exp_q: 22};

        rst_n   = 1'b0;
        d_in    = '0;
        d_valid = 1'b0;
        clear   = 1'b0;
        idle(3);
        chk("rst_q", int'(q), 0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        idle(2);

        // initial fill
        send(6'd20, 1'b1, 20, 9);
        chk("fill_busy_start", int'(busy), 1);
        bcnt = 1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (!busy) break;
            bcnt++;
        end
        chk("fill_busy_len", bcnt, 8);
        chk("fill_q", int'(q), 20);
        chk("fill_locked", int'(locked), 1);
        chk("fill_sum", int'(dut.u_ring.sum), 160);
        idle(2);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].d, vecs[i].upd, vecs[i].exp_q, 2);
            idle(2);
            chk("vec_q", int'(q), vecs[i].exp_q);
            chk("vec_locked", int'(locked), 1);
            chk("vec_busy", int'(busy), 0);
        end
        chk("vec_sum", int'(dut.u_ring.sum), 177);

        // scene change: three consecutive outliers refill the window
        send(6'd40, 1'b0, 0, 2);
        idle(1);
        chk("scene_drop1_q", int'(q), 22);
        send(6'd40, 1'b0, 0, 2);
        idle(1);
        chk("scene_drop2_locked", int'(locked), 1);
        send(6'd40, 1'b1, 40, 9);
        chk("scene_locked_low", int'(locked), 0);
        chk("scene_busy", int'(busy), 1);
        idle(4);
        chk("scene_q_held", int'(q), 22);
        idle(5);
        chk("scene_q", int'(q), 40);
        chk("scene_locked", int'(locked), 1);
        chk("scene_busy_done", int'(busy), 0);
        chk("scene_sum", int'(dut.u_ring.sum), 320);

        // back-to-back accepts give consecutive q_valid pulses
        send(6'd47, 1'b1, 41, 2);
        send(6'd48, 1'b1, 42, 2);
        idle(2);
        chk("b2b_q", int'(q), 42);
        idle(1);

        // 51 is tested against pre-update q=42 (diff 9) and must be dropped
        send(6'd50, 1'b1, 43, 2);
        send(6'd51, 1'b0, 0, 2);
        idle(3);
        chk("preupd_q", int'(q), 43);
        chk("preupd_sum", int'(dut.u_ring.sum), 345);

        // clear from RUN, then clear during FLUSH
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clr_locked", int'(locked), 0);
        chk("clr_sum", int'(dut.u_ring.sum), 0);
        send(6'd30, 1'b0, 0, 9);
        idle(3);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clrflush_busy", int'(busy), 0);
        chk("clrflush_locked", int'(locked), 0);
        chk("clrflush_q", int'(q), 43);
        idle(12);
        chk("clrflush_q_later", int'(q), 43);
        chk("clrflush_busy_later", int'(busy), 0);
        send(6'd25, 1'b1, 25, 9);
        idle(9);
        chk("refill_q", int'(q), 25);
        chk("refill_locked", int'(locked), 1);
        chk("refill_sum", int'(dut.u_ring.sum), 200);

        // async reset mid-RUN with a stage-2 update pending
        send(6'd26, 1'b0, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_q_valid", int'(q_valid), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(6'd12, 1'b1, 12, 9);
        idle(9);
        chk("post_rst_q", int'(q), 12);
        chk("post_rst_locked", int'(locked), 1);

        idle(3);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
